// File: rtl/bitpos_pkg.sv
// ----------------------------------------------------------------------------
// bitpos_pkg
//
// Purpose:
//     Shared definitions for the sequential bit-position scanner: the
//     scanner state encoding, a clog2 helper usable in parameter
//     expressions, and a population-count function that works for any
//     word width up to POPCOUNT_MAX_W.
//
// Contents:
//     state_t         IDLE (waiting for a word) / SCAN (emitting positions)
//     POPCOUNT_MAX_W  widest word popcount() can count
//     clog2()         ceiling log2, constant-foldable
//     popcount()      number of set bits in the low 'width' bits of a word
// ----------------------------------------------------------------------------
package bitpos_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int POPCOUNT_MAX_W = 256;

    // Ceiling log2 written as a bounded loop so it folds to a constant
    // when used in parameter and port-width expressions. Returns 0 for
    // values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Counts the set bits in the low 'width' bits of a word. Callers
    // zero-extend their word to POPCOUNT_MAX_W bits and pass their real
    // width, so one function serves every instance width.
    function automatic int unsigned popcount(
        input logic [POPCOUNT_MAX_W-1:0] value,
        input int                        width
    );
        int unsigned count;
        count = 0;
        for (int i = 0; i < POPCOUNT_MAX_W; i++) begin
            if ((i < width) && value[i]) begin
                count = count + 1;
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/bitpos_prio.sv
// ----------------------------------------------------------------------------
// bitpos_prio
//
// Purpose:
//     Combinational priority encoder. Reports the index of the
//     highest-priority set bit of 'mask'. The lowest set bit wins when
//     MSB_FIRST is 0, and the highest set bit wins when MSB_FIRST is 1.
//     This is the general form of a one-hot encoder: any number of bits
//     may be set. An all-zero mask reports position 0, so the output is
//     never X.
//
// Parameters:
//     WIDTH      mask width (at least 2)
//     MSB_FIRST  0 = lowest set bit wins, 1 = highest set bit wins
//
// Ports:
//     mask      in   WIDTH   bits still to be reported
//     position  out  POS_W   index of the winning set bit (0 if mask is 0)
//     one_left  out  1       exactly one bit of mask is set
// ----------------------------------------------------------------------------
module bitpos_prio
    import bitpos_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int MSB_FIRST = 0,
    localparam int POS_W     = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] mask,
    output logic [POS_W-1:0] position,
    output logic             one_left
);

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            // Walk upward so the last hit, which is the highest set bit,
            // overwrites any earlier ones.
            always_comb begin
                position = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (mask[i]) begin
                        position = POS_W'(i);
                    end
                end
            end
        end else begin : g_lsb_first
            // Walk downward so the last hit, which is the lowest set bit,
            // overwrites any earlier ones.
            always_comb begin
                position = '0;
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (mask[i]) begin
                        position = POS_W'(i);
                    end
                end
            end
        end
    endgenerate

    // Clearing the lowest set bit of a word with exactly one bit set
    // leaves zero. This gives a "single bit left" flag without a full
    // popcount.
    assign one_left = (mask != '0) && ((mask & (mask - WIDTH'(1))) == '0);

endmodule

// File: rtl/bitpos_scan.sv
// ----------------------------------------------------------------------------
// bitpos_scan
//
// Purpose:
//     Sequential bit-position scanner. It accepts a WIDTH-bit word on a
//     valid/ready handshake and then emits the index of each set bit, one
//     per accepted output beat, in LSB-first or MSB-first order. The final
//     position of each word is flagged with out_last. The word's popcount
//     is held on bit_count. When an all-zero word is accepted, no beats are
//     produced and zero_seen pulses for one cycle instead.
//
// Parameters:
//     WIDTH      input word width (at least 2)
//     MSB_FIRST  0 = scan from bit 0 upward, 1 = scan from bit WIDTH-1 down
//     POS_W      derived width of bit_position
//
// Ports:
//     clk            in   1        rising-edge clock
//     rst_n          in   1        asynchronous active-low reset
//     in_valid       in   1        binary_number is valid
//     in_ready       out  1        a word can be accepted this cycle
//     binary_number  in   WIDTH    word to scan
//     out_valid      out  1        bit_position is valid
//     out_ready      in   1        consumer takes the current position
//     bit_position   out  POS_W    index of the current set bit
//     out_last       out  1        current position is the word's final one
//     bit_count      out  POS_W+1  popcount of the word being scanned
//     zero_seen      out  1        pulse: an all-zero word was accepted
// ----------------------------------------------------------------------------
module bitpos_scan
    import bitpos_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int MSB_FIRST = 0,
    localparam int POS_W     = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] binary_number,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] bit_position,
    output logic             out_last,
    output logic [POS_W:0]   bit_count,
    output logic             zero_seen
);

    state_t           r_state;
    logic [WIDTH-1:0] r_mask;
    logic [POS_W:0]   r_count;
    logic             r_zero_seen;

    logic [POS_W-1:0] w_position;
    logic             w_one_left;
    logic             w_accept;
    logic             w_pop;
    logic [WIDTH-1:0] w_clear;
    logic [POS_W:0]   w_word_popcount;

    // The priority encoder sees only the mask register, so bit_position
    // and out_last never depend combinationally on the input side.
    bitpos_prio #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio (
        .mask     (r_mask),
        .position (w_position),
        .one_left (w_one_left)
    );

    // A new word may be taken while idle, or on the edge that consumes the
    // last beat of the current word. The second case uses the
    // combinational out_ready -> in_ready path, so consecutive words run
    // with no idle cycle between them.
    assign out_valid = (r_state == SCAN);
    assign out_last  = out_valid && w_one_left;
    assign in_ready  = (r_state == IDLE) || (out_last && out_ready);

    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // One-hot of the bit being reported; it is removed from the mask when
    // the consumer takes the beat.
    assign w_clear   = WIDTH'(1) << w_position;

    // The word is zero-extended to the package's maximum width so a single
    // popcount function serves any WIDTH.
    assign w_word_popcount =
        (POS_W + 1)'(popcount(POPCOUNT_MAX_W'(binary_number), WIDTH));

    assign bit_position = w_position;
    assign bit_count    = r_count;
    assign zero_seen    = r_zero_seen;

    // Scanner state, mask, popcount and zero-word pulse.
    //
    // Accepting a word has priority over the last-beat pop. On a
    // back-to-back edge the old mask is replaced outright by the new word,
    // so it never needs clearing separately.
    //
    // An all-zero word has nothing to emit. It leaves the block idle, loads
    // a count of zero and raises zero_seen for the following cycle only.
    //
    // While the consumer stalls, neither branch fires, so the mask and the
    // count hold their values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_count     <= '0;
            r_zero_seen <= 1'b0;
        end else begin
            r_zero_seen <= 1'b0;
            if (w_accept) begin
                r_mask      <= binary_number;
                r_count     <= w_word_popcount;
                r_zero_seen <= (binary_number == '0);
                r_state     <= (binary_number == '0) ? IDLE : SCAN;
            end else if (w_pop) begin
                r_mask <= r_mask & ~w_clear;
                if (w_one_left) begin
                    r_state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bitpos_scan.sv
// ----------------------------------------------------------------------------
// tb_bitpos_scan
//
// Purpose:
//     Self-checking bench for bitpos_scan. It builds an LSB-first and an
//     MSB-first instance and drives both with the same inputs. A queue
//     model predicts every output of both instances, cycle by cycle.
//     Directed scenarios then pin the model with hand-computed values.
// ----------------------------------------------------------------------------
module tb_bitpos_scan;

    localparam int WIDTH = 8;
    localparam int POS_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             inValid = 1'b0;
    logic             outReady = 1'b0;
    logic [WIDTH-1:0] binaryNumber = '0;

    logic             inReadyL, outValidL, outLastL, zeroSeenL;
    logic [POS_W-1:0] bitPosL;
    logic [POS_W:0]   bitCountL;

    logic             inReadyM, outValidM, outLastM, zeroSeenM;
    logic [POS_W-1:0] bitPosM;
    logic [POS_W:0]   bitCountM;

    int checksTotal  = 0;
    int checksPassed = 0;

    // Model state: pending positions of the current word, in emit order.
    int qL[$];
    int qM[$];
    int modelCount = 0;
    bit modelZero  = 1'b0;

    bitpos_scan #(.WIDTH(WIDTH), .MSB_FIRST(0)) dutLsb (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (inValid),
        .in_ready      (inReadyL),
        .binary_number (binaryNumber),
        .out_valid     (outValidL),
        .out_ready     (outReady),
        .bit_position  (bitPosL),
        .out_last      (outLastL),
        .bit_count     (bitCountL),
        .zero_seen     (zeroSeenL)
    );

    bitpos_scan #(.WIDTH(WIDTH), .MSB_FIRST(1)) dutMsb (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (inValid),
        .in_ready      (inReadyM),
        .binary_number (binaryNumber),
        .out_valid     (outValidM),
        .out_ready     (outReady),
        .bit_position  (bitPosM),
        .out_last      (outLastM),
        .bit_count     (bitCountM),
        .zero_seen     (zeroSeenM)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Compares one value with its required value and counts the result.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Drives the inputs of both instances.
    task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] word,
                                 input logic ready);
        inValid      = valid;
        binaryNumber = word;
        outReady     = ready;
    endtask

    // Waits for the next rising edge, then lets the outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one output beat on both instances against literal values.
    task automatic checkBeat(input string tag, input int posL, input int posM,
                             input bit last, input int count);
        checkOutput({tag, "_valid_lsb"}, outValidL, 1);
        checkOutput({tag, "_valid_msb"}, outValidM, 1);
        checkOutput({tag, "_pos_lsb"}, bitPosL, posL);
        checkOutput({tag, "_pos_msb"}, bitPosM, posM);
        checkOutput({tag, "_last_lsb"}, outLastL, last);
        checkOutput({tag, "_last_msb"}, outLastM, last);
        checkOutput({tag, "_count_lsb"}, bitCountL, count);
        checkOutput({tag, "_count_msb"}, bitCountM, count);
    endtask

    // The model is checked on the falling edge, half a cycle away from the
    // active edge. Inputs only change just after a rising edge, so the
    // values seen here are also the ones the next rising edge will act on.
    // The model therefore advances here too.
    always @(negedge clk) begin
        int  expPosL;
        int  expPosM;
        bit  expValid;
        bit  expLast;
        bit  expReady;
        bit  accept;
        if (!rst_n) begin
            qL.delete();
            qM.delete();
            modelCount = 0;
            modelZero  = 1'b0;
        end else begin
            expValid = (qL.size() > 0);
            expPosL  = expValid ? qL[0] : 0;
            expPosM  = expValid ? qM[0] : 0;
            expLast  = (qL.size() == 1);
            expReady = (qL.size() == 0) || ((qL.size() == 1) && outReady);

            checkOutput("cmp_valid_lsb", outValidL, expValid);
            checkOutput("cmp_valid_msb", outValidM, expValid);
            checkOutput("cmp_pos_lsb", bitPosL, expPosL);
            checkOutput("cmp_pos_msb", bitPosM, expPosM);
            checkOutput("cmp_last_lsb", outLastL, expLast);
            checkOutput("cmp_last_msb", outLastM, expLast);
            checkOutput("cmp_count_lsb", bitCountL, modelCount);
            checkOutput("cmp_count_msb", bitCountM, modelCount);
            checkOutput("cmp_zero_lsb", zeroSeenL, modelZero);
            checkOutput("cmp_zero_msb", zeroSeenM, modelZero);
            checkOutput("cmp_ready_lsb", inReadyL, expReady);
            checkOutput("cmp_ready_msb", inReadyM, expReady);

            accept = inValid && expReady;
            if (expValid && outReady) begin
                void'(qL.pop_front());
                void'(qM.pop_front());
            end
            modelZero = 1'b0;
            if (accept) begin
                qL.delete();
                qM.delete();
                for (int i = 0; i < WIDTH; i++) begin
                    if (binaryNumber[i]) qL.push_back(i);
                end
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (binaryNumber[i]) qM.push_back(i);
                end
                modelCount = $countones(binaryNumber);
                modelZero  = (binaryNumber == '0);
            end
        end
    end

    // Stops a hung run, reporting it as a failure first.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios with hand-computed expectations, followed by a
    // short mixed run in which the queue model carries the checking.
    initial begin
        int         multiL[4]   = '{1, 2, 4, 7};
        int         multiM[4]   = '{7, 4, 2, 1};
        logic [7:0] mixWords[6] = '{8'hA5, 8'h81, 8'h40, 8'h00, 8'hFF, 8'h3C};
        bit         acc;
        int         budget;

        applyStimulus(1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("reset_ready", inReadyL, 1);
        checkOutput("reset_valid", outValidL, 0);
        checkOutput("reset_pos", bitPosL, 0);
        checkOutput("reset_count", bitCountL, 0);
        checkOutput("reset_last", outLastL, 0);
        checkOutput("reset_zero", zeroSeenL, 0);
        @(posedge clk);
        #1;

        // Single set bit
        applyStimulus(1'b1, 8'h01, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkBeat("single", 0, 0, 1'b1, 1);
        tick();
        checkOutput("single_done_lsb", outValidL, 0);
        checkOutput("single_done_msb", outValidM, 0);

        // Several set bits, consumer always ready
        applyStimulus(1'b1, 8'b10010110, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checkBeat("multi", multiL[k], multiM[k], (k == 3), 4);
            tick();
        end
        checkOutput("multi_done", outValidL, 0);

        // All ones: eight beats, count needs the extra bit
        applyStimulus(1'b1, 8'hFF, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 8; k++) begin
            checkBeat("ones", k, 7 - k, (k == 7), 8);
            tick();
        end
        checkOutput("ones_done", outValidL, 0);

        // Backpressure on the first beat for three cycles
        applyStimulus(1'b1, 8'b00000110, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) outReady = 1'b1;
            checkBeat("bp_hold", 1, 2, 1'b0, 2);
            checkOutput("bp_ready", inReadyL, 0);
            tick();
        end
        checkBeat("bp_second", 2, 1, 1'b1, 2);
        tick();
        checkOutput("bp_done", outValidL, 0);

        // Back-to-back single-bit words, in_valid held high
        applyStimulus(1'b1, 8'b00000100, 1'b1);
        tick();
        checkBeat("b2b_first", 2, 2, 1'b1, 1);
        checkOutput("b2b_ready_last", inReadyL, 1);
        applyStimulus(1'b1, 8'b00001000, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkBeat("b2b_second", 3, 3, 1'b1, 1);
        tick();
        checkOutput("b2b_done", outValidL, 0);

        // All-zero word
        applyStimulus(1'b1, 8'h00, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("zero_pulse_lsb", zeroSeenL, 1);
        checkOutput("zero_pulse_msb", zeroSeenM, 1);
        checkOutput("zero_valid", outValidL, 0);
        checkOutput("zero_ready", inReadyL, 1);
        checkOutput("zero_count", bitCountL, 0);
        tick();
        checkOutput("zero_pulse_end", zeroSeenL, 0);

        // Reset during the second beat, then a clean word
        applyStimulus(1'b1, 8'b10010110, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkBeat("rst_beat1", 1, 7, 1'b0, 4);
        tick();
        checkBeat("rst_beat2", 2, 4, 1'b0, 4);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_valid_drop", outValidL, 0);
        checkOutput("rst_valid_drop_msb", outValidM, 0);
        checkOutput("rst_count", bitCountL, 0);
        checkOutput("rst_pos", bitPosL, 0);
        checkOutput("rst_ready", inReadyL, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 8'b00011000, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkBeat("after_rst1", 3, 4, 1'b0, 2);
        tick();
        checkBeat("after_rst2", 4, 3, 1'b1, 2);
        tick();
        checkOutput("after_rst_done", outValidL, 0);

        // Mixed words under a randomly toggling consumer
        foreach (mixWords[w]) begin
            inValid      = 1'b1;
            binaryNumber = mixWords[w];
            budget       = 0;
            do begin
                outReady = 1'($urandom_range(0, 1));
                #1;
                acc = inReadyL;
                @(posedge clk);
                #1;
                budget++;
            end while (!acc && budget < 64);
            checkOutput("mix_accept", acc, 1);
            inValid = 1'b0;
        end
        outReady = 1'b1;
        budget   = 0;
        while (outValidL && budget < 64) begin
            tick();
            budget++;
        end
        checkOutput("mix_drain", outValidL, 0);
        tick();

        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/bitpos_scan.md
Name: bitpos_scan

Overview:
- Parametrised, sequential successor to the combinational bit-position encoder.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Emits the position of every set bit, one per accepted output beat, in LSB-first or MSB-first order.
- Flags the last position of each word and reports the word's popcount. Sits between status/interrupt vectors and per-bit service logic.

Parameters:
- WIDTH, 8, input word width; must be at least 2.
- MSB_FIRST, 0: 0 = scan from bit 0 upward; 1 = scan from bit WIDTH-1 downward.
- POS_W, $clog2(WIDTH), derived localparam; width of bit_position.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  binary_number is valid
- in_ready  out  1  block can accept a word this cycle
- binary_number  in  WIDTH  word to scan
- out_valid  out  1  bit_position is valid
- out_ready  in  1  consumer accepts the current position
- bit_position  out  POS_W  index of the current set bit
- out_last  out  1  current position is the final set bit of the word
- bit_count  out  POS_W+1  popcount of the word being scanned
- zero_seen  out  1  one-cycle pulse: an all-zero word was accepted

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - State is IDLE; mask register is 0.
  - out_valid=0, out_last=0, bit_position=0, bit_count=0, zero_seen=0, in_ready=1.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SCAN: out_valid=1.
- Accept: when in_valid&&in_ready at a clock edge:
  - The mask register loads binary_number.
  - bit_count loads popcount(binary_number).
  - If the word is nonzero, the next state is SCAN; otherwise the state stays/returns to IDLE and zero_seen pulses for exactly one cycle.
- Latency: 1 cycle from the accept edge to the first out_valid.
- In SCAN:
  - bit_position is the lowest set bit of the mask (MSB_FIRST=0) or the highest (MSB_FIRST=1). It is combinational from the mask register only, never from the inputs.
  - out_last=1 when exactly one mask bit remains.
- Output handshake: when out_valid&&out_ready, the reported bit is cleared from the mask.
  - If out_last=1, the next state is IDLE, unless a new word is accepted on the same edge.
- in_ready = IDLE || (SCAN && out_last && out_ready). The combinational path out_ready -> in_ready is permitted and required.
  - It allows back-to-back words with no bubble: the last beat of word N and the first beat of word N+1 are on consecutive cycles.
- Backpressure:
  - While out_valid && !out_ready, bit_position, out_last, bit_count and the mask hold stable.
  - in_ready=0 unless the IDLE or last-beat condition above holds.
- Throughput: one position per cycle with out_ready held high.
- Stability: bit_count holds from the accept until the next accept.
- All-ones word: WIDTH beats; out_last is set on beat WIDTH; bit_count=WIDTH, which requires the POS_W+1 width.
- in_valid while not ready: the word is ignored; the source must hold it (standard valid/ready).
- Reset mid-scan: the remaining positions are discarded; all outputs return to their reset values asynchronously.
- No X propagation: bit_position is 0 whenever the mask is 0.

Decomposition:
- Shared package bitpos_pkg holds:
  - the state encoding (IDLE=1'b0, SCAN=1'b1);
  - a clog2 helper function;
  - a popcount function parametrised on width.
- One natural sub-module: bitpos_prio, a combinational priority encoder.
  - Parameters: WIDTH, MSB_FIRST. Input: mask. Outputs: position, one_left.
  - Instantiated once. It is the generalised form of the original one-hot encoder, now tolerant of multiple set bits.

Test Plan:
- Reset check: after reset release -> in_ready=1, out_valid=0, bit_position=0, bit_count=0.
  - Send 8'b10010110 and assert rst_n=0 during the second output beat -> out_valid drops immediately; the next word scans cleanly.
- Single bit: 8'b00000001 accepted, out_ready=1 -> one cycle later out_valid=1, bit_position=0, out_last=1, bit_count=1; the next cycle out_valid=0.
- Multi-bit LSB-first: 8'b10010110, out_ready=1 -> positions 1,2,4,7 on consecutive cycles; out_last only on 7; bit_count=4 throughout.
- MSB-first and all-ones:
  - MSB_FIRST=1 with the same word -> 7,4,2,1.
  - 8'hFF -> 8 beats, 7..0, bit_count=8.
- Backpressure and back-to-back:
  - 8'b00000110 with out_ready low for 3 cycles on the first beat -> bit_position holds at 1 for 4 cycles, then 2.
  - 8'b00000100 then 8'b00001000 with in_valid continuous -> positions 2 and 3 on adjacent cycles; in_ready=1 on the last beat.
- Zero word: 8'b00000000 accepted -> zero_seen=1 for exactly one cycle, no out_valid, in_ready stays 1, bit_count=0.
